// File: rtl/seq_pkg.sv
// Shared definitions for the 11001 pattern transmitter and the matching sequence detectors.
// Holds the state encoding and the default pattern constant.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } seq_state_e;

    localparam int         SEQ_PAT_W = 5;
    localparam logic [4:0] PAT_11001 = 5'b11001;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Command/stream bundle between a frame requester (master) and the pattern transmitter (slave).
// Signal names are the transmitter's external port names.
interface seq_pattern_tx_if #(
    parameter int REP_W = 4,
    parameter int GAP_W = 3
);
    logic             start;
    logic [REP_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             abort;
    logic             dout;
    logic             dout_vld;
    logic             frame_sof;
    logic             busy;
    logic             done;

    modport master (
        output start, rep_cnt, gap_len, abort,
        input  dout, dout_vld, frame_sof, busy, done
    );

    modport slave (
        input  start, rep_cnt, gap_len, abort,
        output dout, dout_vld, frame_sof, busy, done
    );
endinterface

// File: rtl/seq_piso_shift.sv
// Parallel-load, MSB-first shift register; zeros are shifted in at the LSB.
// Priority: clear > load > shift.
module seq_piso_shift
    import seq_pkg::*;
#(
    parameter int PAT_W = SEQ_PAT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [PAT_W-1:0] pdata_i,
    output logic             ser_o
);
    logic [PAT_W-1:0] sr_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= pdata_i;
        end else if (shift_i) begin
            sr_q <= {sr_q[PAT_W-2:0], 1'b0};
        end
    end

    assign ser_o = sr_q[PAT_W-1];
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: emits PATTERN MSB-first with optional repetitions and zero gaps.
// dout is the shifter's MSB flop; zeros shifted in after the LSB keep it low in GAP and IDLE.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int               PAT_W   = SEQ_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_11001,
    parameter int               REP_W   = 4,
    parameter int               GAP_W   = 3
) (
    input  logic            clk,
    input  logic            reset,
    seq_pattern_tx_if.slave bus
);
    localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    seq_state_e       state_q,   state_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [REP_W-1:0] rep_q,     rep_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             vld_q,     vld_d;
    logic             sof_q,     sof_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    logic sh_clr, sh_load, sh_shift, sh_ser;

    seq_piso_shift #(
        .PAT_W (PAT_W)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (sh_clr),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .pdata_i (PATTERN),
        .ser_o   (sh_ser)
    );

    // NOTE: every signal gets a default before the branches, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        rep_d     = rep_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        vld_d     = vld_q;
        sof_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sh_clr    = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;

        if (state_q == IDLE) begin
            if (bus.start && !bus.abort) begin
                rep_d     = bus.rep_cnt;
                gap_len_d = bus.gap_len;
                bit_idx_d = IDX_MSB;
                sh_load   = 1'b1;
                state_d   = SEND;
                vld_d     = 1'b1;
                sof_d     = 1'b1;
                busy_d    = 1'b1;
            end
        end else if (bus.abort) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            sh_clr  = 1'b1;
        end else if (state_q == GAP) begin
            if (gap_cnt_q == GAP_W'(1)) begin
                bit_idx_d = IDX_MSB;
                sh_load   = 1'b1;
                state_d   = SEND;
                sof_d     = 1'b1;
            end else begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
        end else if (bit_idx_q != '0) begin
            bit_idx_d = bit_idx_q - IDX_W'(1);
            sh_shift  = 1'b1;
        end else if (rep_q != '0) begin
            // LSB on the wire with repetitions left: either open a gap or restart back-to-back.
            rep_d = rep_q - REP_W'(1);
            if (gap_len_q != '0) begin
                gap_cnt_d = gap_len_q;
                sh_shift  = 1'b1;
                state_d   = GAP;
            end else begin
                bit_idx_d = IDX_MSB;
                sh_load   = 1'b1;
                sof_d     = 1'b1;
            end
        end else begin
            state_d = IDLE;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            sh_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            rep_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            vld_q     <= 1'b0;
            sof_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            rep_q     <= rep_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            vld_q     <= vld_d;
            sof_q     <= sof_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.dout      = sh_ser;
    assign bus.dout_vld  = vld_q;
    assign bus.frame_sof = sof_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: on command, emits a fixed bit pattern (default 11001) MSB-first, one bit per clock, with a valid qualifier.
- Supports programmable repetitions and zero-filled gaps between repetitions.
- Drives the din input of the team's 11001 sequence-detector FSMs, both in benches and as an on-chip link self-test source.

Parameters:
- PAT_W, 5, pattern length in bits.
- PATTERN, 5'b11001, bit pattern; MSB is transmitted first.
- REP_W, 4, width of the repetition-count input.
- GAP_W, 3, width of the gap-length input.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a frame; sampled only while busy=0.
- rep_cnt  input  REP_W  number of repetitions minus 1 (0 gives one pattern); latched at start.
- gap_len  input  GAP_W  number of 0 bits inserted between repetitions; latched at start.
- abort  input  1  terminate the frame in progress.
- dout  output  1  serial data bit.
- dout_vld  output  1  dout carries a stream bit (pattern or gap).
- frame_sof  output  1  high with the first bit of each pattern repetition.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the final bit of a completed frame.

Behaviour:
- Reset values: reset is synchronous, active-high, on clock clk. At reset all outputs are 0, state is IDLE, and the counters and latched inputs clear. Reset mid-frame forces all outputs to 0 at the next edge, with no done pulse.
- All outputs are registered.
- States:
  - IDLE: dout=0, dout_vld=0, busy=0.
  - SEND: shift out PATTERN.
  - GAP: emit gap_len zeros.
- Accepting start:
  - start=1 in IDLE at edge t latches rep_cnt and gap_len and loads the shift register with PATTERN.
  - From edge t+1, dout=PATTERN[PAT_W-1], dout_vld=1, frame_sof=1, busy=1, state=SEND.
- SEND: one bit per cycle, MSB to LSB. frame_sof is high only on the MSB bit.
- After the LSB bit:
  - If repetitions remain and gap_len>0, go to GAP.
  - If repetitions remain and gap_len=0, reload the pattern and continue SEND with no bubble, so consecutive patterns are contiguous.
  - Otherwise go to IDLE.
- GAP: gap_len cycles of dout=0, dout_vld=1, then SEND with frame_sof=1.
- Frame length: busy is high for exactly (rep_cnt+1)*PAT_W + rep_cnt*gap_len cycles, with dout_vld=1 throughout.
- Completion: in the cycle after the final LSB bit, state=IDLE, busy=0, dout_vld=0, done=1 for exactly one cycle.
  - start is accepted in that same cycle, so back-to-back frames have exactly one idle cycle between them.
- start while busy=1 is ignored, with no queuing. rep_cnt and gap_len changes while busy have no effect.
- abort:
  - abort=1 while busy: next edge goes to IDLE with dout=0, dout_vld=0, busy=0, done=0.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: abort wins and start is ignored.
- Counters:
  - Bit index is ceil(log2(PAT_W)) bits wide.
  - The repetition down-counter is REP_W wide and the gap counter is GAP_W wide.
  - No wrap-around is possible, because counters are loaded from latched inputs and stop at 0.
- Maximum frame (default parameters) is 16*5 + 15*7 = 185 cycles.

Decomposition:
- Shared package (seq_pkg):
  - state encoding constants IDLE/SEND/GAP (2-bit);
  - the default pattern constant PAT_11001 = 5'b11001;
  - PAT_W default.
  - The detector side reuses PAT_11001.
- One sub-module: seq_piso_shift, a PAT_W-bit parallel-load, MSB-first shift register with load/shift enables and serial output.
- The FSM and the three counters stay in seq_pattern_tx.

Test Plan:
- Single frame: rep_cnt=0, gap_len=0, start at edge t -> dout 1,1,0,0,1 at edges t+1..t+5; frame_sof only at t+1; busy high 5 cycles; done=1 at t+6.
- Loopback to the 11001 detector: rep_cnt=1, gap_len=0 -> stream 1100111001 over 10 cycles, contiguous. Detector y=1 on the cycles where its input is stream bit 5 and stream bit 10 (exactly 2 detections); done at cycle 11.
- Gap insertion: rep_cnt=1, gap_len=2 -> 110010011001 with dout_vld=1 for all 12 bits; frame_sof at bit 1 and bit 8; done after 12 busy cycles.
- Abort after the 3rd bit (dout was 1,1,0), abort=1 -> next cycle dout_vld=0, busy=0, done never asserted. A subsequent start produces a fresh full 11001.
- start pulsed while busy, plus start in the done cycle: the mid-frame start is ignored with the frame unchanged; the done-cycle start begins a new frame one cycle later. abort+start together in IDLE -> no frame.
- reset=1 mid-GAP -> all outputs 0 at the next edge. After reset is released, stays IDLE until start.
